// File: rtl/fp_pkg.sv
// fp_pkg: shared minifloat types, rounding modes and exponent bias helper
package fp_pkg;
  typedef enum logic [0:0] {ROUND_NEAREST} round_t;
  typedef enum logic [2:0] {FP_ZERO, FP_SUB, FP_NORM, FP_INF, FP_NAN} fp_class_t;
  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction
endpackage

// File: rtl/fp_unpack.sv
// fp_unpack: splits a minifloat into sign, class, effective exponent and significand
module fp_unpack
  import fp_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EXP_WIDTH = 5,
  parameter int MAN_WIDTH = 2
)(
  input  logic [WIDTH-1:0]     fp,
  output logic                 sign,
  output fp_class_t            cls,
  output logic [EXP_WIDTH-1:0] e_eff,
  output logic [MAN_WIDTH:0]   m
);
  logic [EXP_WIDTH-1:0] e;
  logic [MAN_WIDTH-1:0] f;
  logic e_zero, e_max;
  always_comb begin
    {sign, e, f} = fp;
    e_zero = ~|e;
    e_max = &e;
    cls = e_zero ? (|f ? FP_SUB : FP_ZERO) : e_max ? (|f ? FP_NAN : FP_INF) : FP_NORM;
    e_eff = e_zero ? EXP_WIDTH'(1) : e;
    m = {~e_zero, f};
  end
endmodule

// File: rtl/fp8_to_fixed.sv
// fp8_to_fixed: iterative minifloat to signed fixed-point converter with RNE rounding and saturation
module fp8_to_fixed
  import fp_pkg::*;
#(
  parameter round_t ROUNDING  = ROUND_NEAREST,
  parameter int     WIDTH     = 8,
  parameter int     EXP_WIDTH = 5,
  parameter int     MAN_WIDTH = 2,
  parameter int     OUT_WIDTH = 16,
  parameter int     FRAC_BITS = 8
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     fp_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] fx_out,
  output logic [2:0]           flags
);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, ROUND = 2'd2, DONE = 2'd3;
  localparam logic [OUT_WIDTH-1:0] LIM_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] LIM_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam int BIAS = bias(EXP_WIDTH);
  logic [1:0] state;
  logic [OUT_WIDTH-1:0] mag, lim, rnd;
  logic [15:0] cnt;
  logic sign, right, guard, sticky, ovf, round_up;
  logic u_sign;
  fp_class_t u_cls;
  logic [EXP_WIDTH-1:0] u_e;
  logic [MAN_WIDTH:0] u_m;
  int k;
  fp_unpack #(.WIDTH(WIDTH), .EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH)) u_unpack (
    .fp(fp_in), .sign(u_sign), .cls(u_cls), .e_eff(u_e), .m(u_m)
  );
  always_comb begin
    k = int'(u_e) - BIAS - MAN_WIDTH + FRAC_BITS;
    lim = sign ? LIM_NEG : LIM_POS;
    round_up = ROUNDING == ROUND_NEAREST && !ovf && guard && (sticky || mag[0]);
    rnd = mag + OUT_WIDTH'(round_up);
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fx_out <= '0;
      flags <= '0;
      mag <= '0;
      cnt <= '0;
      sign <= 1'b0;
      right <= 1'b0;
      guard <= 1'b0;
      sticky <= 1'b0;
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign <= u_sign;
          mag <= OUT_WIDTH'(u_m);
          cnt <= 16'(k < 0 ? -k : k);
          right <= k < 0;
          guard <= 1'b0;
          sticky <= 1'b0;
          ovf <= 1'b0;
          if (u_cls inside {FP_ZERO, FP_INF, FP_NAN}) begin
            fx_out <= u_cls == FP_INF ? (u_sign ? LIM_NEG : LIM_POS) : '0;
            flags <= {u_cls == FP_NAN, u_cls == FP_INF, 1'b0};
            state <= DONE;
          end else state <= k == 0 ? ROUND : SHIFT;
        end
        SHIFT: if (right) begin
          mag <= mag >> 1;
          guard <= mag[0];
          sticky <= sticky | guard;
          cnt <= cnt - 16'd1;
          state <= cnt == 16'd1 ? ROUND : SHIFT;
        end else if ({mag, 1'b0} > {1'b0, lim}) begin
          mag <= lim;
          ovf <= 1'b1;
          state <= ROUND;
        end else begin
          mag <= mag << 1;
          cnt <= cnt - 16'd1;
          state <= cnt == 16'd1 ? ROUND : SHIFT;
        end
        ROUND: begin
          fx_out <= sign ? -rnd : rnd;
          flags <= {1'b0, ovf, guard | sticky};
          state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
      endcase
    end
  end
endmodule
